math_divider_restoring: RTL and testbench
=========================================

Name: math_divider_restoring

Overview:
Sequential unsigned restoring divider, the inverse operation of the carry-save multiplier.
- Takes an N-bit dividend and an N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder.
- Computes one quotient bit per clock.
- Start/busy/done handshake lets a controller or bench drive it back-to-back with multiplier results.

Parameters:
N, 4, operand width in bits for dividend, divisor, quotient and remainder; must match the multiplier's default N; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a division; sampled only when busy=0.
a  input  N  dividend; captured on the accepting edge.
b  input  N  divisor; captured on the accepting edge.
busy  output  1  high while a division is in progress.
done  output  1  one-cycle pulse; q and r valid from this cycle onward.
q  output  N  quotient.
r  output  N  remainder.
dz  output  1  divide-by-zero flag; valid with done.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; busy=0, done=0, dz=0, q=0, r=0, internal registers cleared.
- Reset asserted mid-division aborts the operation immediately; no done pulse is produced for that operation.
- States:
  - IDLE: waiting for start.
  - RUN: iterating, with a step counter 0..N-1.
  - DONE: one-cycle state asserting done.
- IDLE to RUN: on the edge where start=1 (edge E0). Latch a and b, clear the partial remainder (N+1 bits) and the counter. busy=1 from E0.
- RUN: each edge E1..EN performs one restoring step, MSB first:
  - shift {rem, dividend MSB} left one bit;
  - compute trial = rem - {0,b};
  - if trial is non-negative, rem=trial and the quotient bit is 1; otherwise rem is unchanged and the quotient bit is 0.
- Completion at edge EN, then RUN to DONE:
  - q and r are updated;
  - busy=0;
  - done=1 for exactly the cycle after EN.
- Latency: done is high N cycles after the accepting edge.
- DONE to IDLE on the next edge. If start=1 in the DONE cycle, it is accepted instead (DONE to RUN) with the same load actions, so back-to-back throughput is N+1 cycles per division.
- q, r and dz hold their values until the next completion. They do not clear on a new start.
- start while busy=1 is ignored; a and b changes during RUN have no effect.
- Width rules:
  - results are unsigned and exact: q*b + r = a and r < b whenever b != 0;
  - the partial remainder is N+1 bits wide so the subtraction sign is its MSB; no overflow is possible.
- b=0 without the optional feature: the algorithm runs normally and yields q = all ones and r = a; dz=0.

Optional Feature:
Macro MATH_DIVIDER_DIVZERO_EN.
- Defined:
  - when b=0 at accept, the divider skips RUN and goes directly to DONE on the next edge (done one cycle after accept);
  - q = all ones, r = a, dz=1;
  - dz=0 for every nonzero-divisor result.
- Undefined: no early exit, and dz is tied to 0. b=0 takes the full N-cycle latency with q = all ones and r = a.

Test Plan:
1. N=4, a=13, b=4, start pulse: busy high 4 cycles, then done pulse; q=3, r=1, dz=0.
2. Exhaustive N=4: every a, b in 0..15 with b != 0, issued back-to-back using start in DONE. Each result satisfies q*b + r = a and r < b. Spacing between done pulses is exactly 5 cycles.
3. Divide by zero, a=9, b=0:
   - without the macro: done after 4 cycles, q=15, r=9, dz=0;
   - with MATH_DIVIDER_DIVZERO_EN: done 1 cycle after accept, q=15, r=9, dz=1.
4. Start while busy: start a=15, b=2, then pulse start with a=6, b=3 two cycles later. The second start is ignored; a single done with q=7, r=1.
5. Reset mid-operation: start a=14, b=3, assert rst for 1 cycle after 2 cycles. Outputs go to 0 immediately; no done follows. A new start of a=14, b=3 gives q=4, r=2.
6. Boundary values: a=0, b=7 gives q=0, r=0; a=15, b=1 gives q=15, r=0; a=5, b=15 gives q=0, r=5.

Source files
------------

// File: rtl/math_divider_restoring.sv
// rtl/math_divider_restoring.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional macro MATH_DIVIDER_DIVZERO_EN: early exit with dz=1 when the divisor is zero.
module math_divider_restoring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_dvd;
    logic [N-1:0]    r_dvs;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_r;
    logic            r_busy;
    logic            r_done;
    logic            r_dz;

    logic [N:0]      w_shift;
    logic [N:0]      w_trial;
    logic            w_qbit;
    logic [N:0]      w_rem_next;
    logic [N-1:0]    w_quo_next;
    logic            w_dz_exit;

    // Dividend register shifts out its MSB and collects quotient bits at the LSB.
    assign w_shift    = {r_rem[N-1:0], r_dvd[N-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_trial[N];
    assign w_rem_next = w_qbit ? w_trial : w_shift;
    assign w_quo_next = {r_dvd[N-2:0], w_qbit};

`ifdef MATH_DIVIDER_DIVZERO_EN
    assign w_dz_exit = (r_dvs == '0);
`else
    assign w_dz_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dvd   <= a;
                        r_dvs   <= b;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_dz_exit) begin
                        r_q     <= '1;
                        r_r     <= r_dvd;
                        r_dz    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dvd <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_q     <= w_quo_next;
                            r_r     <= w_rem_next[N-1:0];
                            r_dz    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;
    assign dz   = r_dz;

endmodule

// File: tb/tb_math_divider_restoring.sv
// tb/tb_math_divider_restoring.sv - randomized self-checking bench for math_divider_restoring
module tb_math_divider_restoring;

    localparam int N = 4;
`ifdef MATH_DIVIDER_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, dz;
    logic [N-1:0] q, r;

    int n_vec = 0;
    int n_err = 0;

    int opa[$];
    int opb[$];

    math_divider_restoring #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all ones and the dividend.
    function automatic void ref_div(input int ia, input int ib,
                                    output int eq, output int er, output int edz, output int elat);
        if (ib == 0) begin
            eq   = (1 << N) - 1;
            er   = ia;
            edz  = DZ_EN ? 1 : 0;
            elat = DZ_EN ? 1 : N;
        end else begin
            eq   = ia / ib;
            er   = ia % ib;
            edz  = 0;
            elat = N;
        end
    endfunction

    task automatic do_one(input int ia, input int ib, input string tag);
        int eq, er, edz, elat, t, bcnt;
        ref_div(ia, ib, eq, er, edz, elat);
        @(negedge clk);
        a = N'(ia); b = N'(ib); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0; bcnt = 0;
        while (!done && t < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1 t++;
        end
        check_eq({tag, ".done"}, 32'(done), 1);
        check_eq({tag, ".lat"}, t, elat);
        check_eq({tag, ".busy_cycles"}, bcnt, elat);
        check_eq({tag, ".q"}, 32'(q), eq);
        check_eq({tag, ".r"}, 32'(r), er);
        check_eq({tag, ".dz"}, 32'(dz), edz);
    endtask

    // Issue every queued operation back-to-back, presenting the next one during each DONE cycle.
    task automatic run_b2b(input string tag);
        int n, t, t_acc, tmo, eq, er, edz, elat, ia, ib;
        n = opa.size();
        @(negedge clk);
        a = N'(opa[0]); b = N'(opb[0]); start = 1'b1;
        @(posedge clk);
        #1;
        t = 0; t_acc = 0;
        for (int i = 0; i < n; i++) begin
            ia = opa[i]; ib = opb[i];
            ref_div(ia, ib, eq, er, edz, elat);
            tmo = 0;
            while (!done && tmo < 40) begin
                @(posedge clk);
                #1 t++; tmo++;
            end
            check_eq({tag, ".done"}, 32'(done), 1);
            check_eq({tag, ".spacing"}, t - t_acc, elat);
            check_eq({tag, ".q"}, 32'(q), eq);
            check_eq({tag, ".r"}, 32'(r), er);
            check_eq({tag, ".dz"}, 32'(dz), edz);
            if (ib != 0) begin
                check_eq({tag, ".identity"}, 32'(q) * 32'(ib) + 32'(r), ia);
                check_eq({tag, ".r_lt_b"}, 32'(r < N'(ib)), 1);
            end
            if (i + 1 < n) begin
                a = N'(opa[i + 1]); b = N'(opb[i + 1]);
            end else begin
                start = 1'b0;
            end
            t_acc = t + 1;
            @(posedge clk);
            #1 t++;
        end
        opa.delete();
        opb.delete();
    endtask

    initial begin
        int dcnt;
        #1;
        check_eq("reset.busy", 32'(busy), 0);
        check_eq("reset.done", 32'(done), 0);
        check_eq("reset.q", 32'(q), 0);
        check_eq("reset.r", 32'(r), 0);
        check_eq("reset.dz", 32'(dz), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_one(13, 4, "basic");

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 1; ib < 16; ib++) begin
                opa.push_back(ia); opb.push_back(ib);
            end
        run_b2b("exh");

        do_one(9, 0, "divzero");

        // Second start during RUN must be ignored.
        @(negedge clk);
        a = 4'd15; b = 4'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        a = 4'd6; b = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 if (done) dcnt++;
        end
        check_eq("busy_start.done_count", dcnt, 1);
        check_eq("busy_start.q", 32'(q), 7);
        check_eq("busy_start.r", 32'(r), 1);

        // Reset mid-division.
        @(negedge clk);
        a = 4'd14; b = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst.busy", 32'(busy), 0);
        check_eq("midrst.done", 32'(done), 0);
        check_eq("midrst.q", 32'(q), 0);
        check_eq("midrst.r", 32'(r), 0);
        check_eq("midrst.dz", 32'(dz), 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (done) dcnt++;
        end
        check_eq("midrst.no_done", dcnt, 0);
        do_one(14, 3, "after_rst");

        do_one(0, 7, "bnd_zero_a");
        do_one(15, 1, "bnd_div1");
        do_one(5, 15, "bnd_small_a");

        for (int i = 0; i < 80; i++) begin
            opa.push_back(int'($urandom_range(0, 15)));
            opb.push_back(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)));
        end
        run_b2b("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
